// File: rtl/yolo_acc_pkg.sv
// Shared constants and FSM state type for the conv output requantiser.
package yolo_acc_pkg;

  localparam int NUM_CLUSTERS  = 8;
  localparam int NUM_PE        = NUM_CLUSTERS * 4;
  localparam int ACC_WIDTH     = 32;
  localparam int ACT_WIDTH     = 16;
  localparam int WORDS_PER_PIX = NUM_PE / 2;
  localparam int WORD_IDX_W    = (WORDS_PER_PIX > 1) ? $clog2(WORDS_PER_PIX) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/conv_out_requant_lane.sv
// One lane: rounding arithmetic right shift, saturation to ACT_WIDTH, optional ReLU.
// ReLU logic exists only when CONV_OUT_RELU_EN is defined.
module conv_out_requant_lane
  import yolo_acc_pkg::*;
(
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [4:0]           shift,
  input  logic                 relu,
  output logic [ACT_WIDTH-1:0] act,
  output logic                 sat
);

  localparam logic signed [ACC_WIDTH:0] ACT_MAX = (ACC_WIDTH+1)'((1 << (ACT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] ACT_MIN = -ACT_MAX - (ACC_WIDTH+1)'(1);

  logic signed [ACC_WIDTH:0] ext_s;
  logic signed [ACC_WIDTH:0] rnd_s;
  logic signed [ACC_WIDTH:0] res_s;
  logic [ACT_WIDTH-1:0]      sat_act_s;

  // Round half up, shift arithmetically, then clip to the activation range
  always_comb begin
    ext_s = {acc[ACC_WIDTH-1], acc};
    if (shift == 5'd0) begin
      rnd_s = ext_s;
    end else begin
      rnd_s = ext_s + ((ACC_WIDTH+1)'(1) << (shift - 5'd1));
    end
    res_s = rnd_s >>> shift;
    if (res_s > ACT_MAX) begin
      sat_act_s = ACT_MAX[ACT_WIDTH-1:0];
      sat       = 1'b1;
    end else if (res_s < ACT_MIN) begin
      sat_act_s = ACT_MIN[ACT_WIDTH-1:0];
      sat       = 1'b1;
    end else begin
      sat_act_s = res_s[ACT_WIDTH-1:0];
      sat       = 1'b0;
    end
  end

`ifdef CONV_OUT_RELU_EN
  // ReLU zeroing happens after saturation and is not a saturation event
  always_comb begin
    if (relu && sat_act_s[ACT_WIDTH-1]) begin
      act = {ACT_WIDTH{1'b0}};
    end else begin
      act = sat_act_s;
    end
  end
`else
  logic unused_relu_s;

  // No ReLU in this build
  always_comb begin
    act           = sat_act_s;
    unused_relu_s = relu;
  end
`endif

endmodule

// File: rtl/conv_out_requant.sv
// Captures one accumulator vector, requantises two lanes per word and streams
// them on AXI-Stream. Optional ReLU via macro CONV_OUT_RELU_EN.
module conv_out_requant
  import yolo_acc_pkg::*;
#(
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [NUM_PE*ACC_WIDTH-1:0]   in_data,
  output logic                          in_ready,
  input  logic [4:0]                    cfg_shift,
  input  logic                          cfg_relu,
  output logic [2*ACT_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [SAT_CNT_WIDTH-1:0]      sat_count,
  output logic                          ovf_err
);

  localparam int PAIR_W = 2 * ACC_WIDTH;
  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_PIX - 1);

  state_e                                  state_q, state_d;
  logic [WORDS_PER_PIX-1:0][PAIR_W-1:0]    data_q, data_d;
  logic                                    last_q, last_d;
  logic [4:0]                              shift_q, shift_d;
  logic                                    relu_q, relu_d;
  logic [WORD_IDX_W-1:0]                   word_idx_q, word_idx_d;
  logic                                    more_q, more_d;
  logic                                    final_q, final_d;
  logic                                    in_ready_q, in_ready_d;
  logic                                    tvalid_q, tvalid_d;
  logic [2*ACT_WIDTH-1:0]                  tdata_q, tdata_d;
  logic                                    tlast_q, tlast_d;
  logic [SAT_CNT_WIDTH-1:0]                sat_count_q, sat_count_d;
  logic                                    ovf_err_q, ovf_err_d;

  logic                  final_accept_s, capture_s, load_s;
  logic [PAIR_W-1:0]     pair_s;
  logic [4:0]            sel_shift_s;
  logic                  sel_relu_s, sel_last_s, sel_final_s;
  logic [ACT_WIDTH-1:0]  act0_s, act1_s;
  logic                  sat0_s, sat1_s;
  logic [SAT_CNT_WIDTH:0] sat_sum_s;

  // Capture may coincide with the final-word handshake; word 0 then comes straight from in_data
  always_comb begin
    final_accept_s = tvalid_q && m_axis_tready && final_q;
    capture_s      = in_valid && (in_ready_q || final_accept_s);
    load_s         = capture_s ||
                     ((state_q == SEND) && more_q && (!tvalid_q || m_axis_tready));
    if (capture_s) begin
      pair_s      = in_data[PAIR_W-1:0];
      sel_shift_s = cfg_shift;
      sel_relu_s  = cfg_relu;
      sel_last_s  = in_last;
      sel_final_s = (WORDS_PER_PIX == 1);
    end else begin
      pair_s      = data_q[word_idx_q];
      sel_shift_s = shift_q;
      sel_relu_s  = relu_q;
      sel_last_s  = last_q;
      sel_final_s = (word_idx_q == LAST_IDX);
    end
  end

  conv_out_requant_lane u_lane_even (
    .acc   (pair_s[ACC_WIDTH-1:0]),
    .shift (sel_shift_s),
    .relu  (sel_relu_s),
    .act   (act0_s),
    .sat   (sat0_s)
  );

  conv_out_requant_lane u_lane_odd (
    .acc   (pair_s[PAIR_W-1:ACC_WIDTH]),
    .shift (sel_shift_s),
    .relu  (sel_relu_s),
    .act   (act1_s),
    .sat   (sat1_s)
  );

  // FSM next state; in_ready mirrors an idle slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_s) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (final_accept_s && !capture_s) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Capture slot, word sequencing, output register and counters
  always_comb begin
    data_d      = data_q;
    last_d      = last_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    word_idx_d  = word_idx_q;
    more_d      = more_q;
    final_d     = final_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    sat_count_d = sat_count_q;
    ovf_err_d   = ovf_err_q || (in_valid && !capture_s);
    sat_sum_s   = {1'b0, sat_count_q} + (SAT_CNT_WIDTH+1)'(sat0_s) + (SAT_CNT_WIDTH+1)'(sat1_s);

    if (capture_s) begin
      data_d     = in_data;
      last_d     = in_last;
      shift_d    = cfg_shift;
      relu_d     = cfg_relu;
      word_idx_d = WORD_IDX_W'(1);
      more_d     = (WORDS_PER_PIX > 1);
    end else if (load_s) begin
      if (word_idx_q == LAST_IDX) begin
        more_d = 1'b0;
      end else begin
        word_idx_d = word_idx_q + WORD_IDX_W'(1);
      end
    end else begin
      word_idx_d = word_idx_q;
    end

    if (load_s) begin
      tvalid_d    = 1'b1;
      tdata_d     = {act1_s, act0_s};
      tlast_d     = sel_final_s && sel_last_s;
      final_d     = sel_final_s;
      sat_count_d = sat_sum_s[SAT_CNT_WIDTH] ? {SAT_CNT_WIDTH{1'b1}}
                                             : sat_sum_s[SAT_CNT_WIDTH-1:0];
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      final_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      data_q      <= '{default: {PAIR_W{1'b0}}};
      last_q      <= 1'b0;
      shift_q     <= 5'd0;
      relu_q      <= 1'b0;
      word_idx_q  <= {WORD_IDX_W{1'b0}};
      more_q      <= 1'b0;
      final_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      tvalid_q    <= 1'b0;
      tdata_q     <= {(2*ACT_WIDTH){1'b0}};
      tlast_q     <= 1'b0;
      sat_count_q <= {SAT_CNT_WIDTH{1'b0}};
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      word_idx_q  <= word_idx_d;
      more_q      <= more_d;
      final_q     <= final_d;
      in_ready_q  <= in_ready_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      sat_count_q <= sat_count_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign sat_count     = sat_count_q;
  assign ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_conv_out_requant.sv
// Scoreboard bench for conv_out_requant: a reference model queues expected
// words at issue time and a monitor checks every accepted output word.
module tb_conv_out_requant;
  import yolo_acc_pkg::*;

  localparam int VW = NUM_PE * ACC_WIDTH;

  logic          aclk = 1'b0;
  logic          areset;
  logic          in_valid, in_last, in_ready, cfg_relu;
  logic [VW-1:0] in_data;
  logic [4:0]    cfg_shift;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [15:0]   sat_count;
  logic          ovf_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  int          sat_model  = 0;
  int          ready_mode = 1;

  conv_out_requant dut (
    .aclk(aclk), .areset(areset), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .sat_count(sat_count), .ovf_err(ovf_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: round half up = floor((a + 2^(s-1)) / 2^s), then clamp
  function automatic logic [15:0] ref_lane(input logic [31:0] acc, input int sh,
                                           input bit relu, output bit clipped);
    longint a, r, d, num;
    a = longint'($signed(acc));
    if (sh == 0) begin
      r = a;
    end else begin
      d   = longint'(1) << sh;
      num = a + d / 2;
      r   = num / d;
      if ((num % d != 0) && (num < 0)) r = r - 1;
    end
    clipped = 1'b0;
    if (r > 32767) begin r = 32767; clipped = 1'b1; end
    else if (r < -32768) begin r = -32768; clipped = 1'b1; end
`ifdef CONV_OUT_RELU_EN
    if (relu && r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  task automatic push_expected(input logic [VW-1:0] vec, input bit last, input int sh, input bit relu);
    logic [15:0] lo, hi;
    bit c0, c1;
    for (int w = 0; w < WORDS_PER_PIX; w++) begin
      lo = ref_lane(vec[(2*w)*32 +: 32], sh, relu, c0);
      hi = ref_lane(vec[(2*w+1)*32 +: 32], sh, relu, c1);
      sat_model += int'(c0) + int'(c1);
      if (sat_model > 65535) sat_model = 65535;
      exp_q.push_back({(w == WORDS_PER_PIX-1) && last, hi, lo});
    end
  endtask

  // Drive a one-cycle pulse now and record its expected words
  task automatic pulse(input logic [VW-1:0] vec, input bit last, input int sh, input bit relu);
    in_data   = vec;
    in_last   = last;
    cfg_shift = 5'(sh);
    cfg_relu  = relu;
    in_valid  = 1'b1;
    push_expected(vec, last, sh, relu);
    @(posedge aclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [VW-1:0] vec, input bit last, input int sh, input bit relu);
    int t = 0;
    @(negedge aclk);
    while (!in_ready && t < 400) begin
      @(negedge aclk);
      t++;
    end
    check("send_wait_ready", 64'(in_ready), 64'd1);
    pulse(vec, last, sh, relu);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge aclk);
    while (!(exp_q.size() == 0 && in_ready) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("wait_idle", 64'(exp_q.size() == 0 && in_ready), 64'd1);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int s;
    for (int i = 0; i < NUM_PE; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        v[i*32 +: 32] = $urandom;
      end else begin
        s = int'($urandom_range(0, 140000)) - 70000;
        v[i*32 +: 32] = 32'(s);
      end
    end
    return v;
  endfunction

  // Ready generator
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake scoreboard, hold-while-stalled, in_ready/tvalid relation
  initial begin
    logic        prev_stall;
    logic [32:0] prev_word;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_word  = 33'd0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        check("ready_vs_valid", 64'(in_ready), 64'(!m_axis_tvalid));
        if (prev_stall) begin
          check("hold_valid", 64'(m_axis_tvalid), 64'd1);
          check("hold_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h with empty scoreboard", {m_axis_tlast, m_axis_tdata});
          end else begin
            e = exp_q.pop_front();
            check("word", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    logic [VW-1:0] v, v2;
    int cnt;
    areset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    cfg_shift = 5'd0; cfg_relu = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    areset = 1'b0;

    // Basic shift=3, full-rate drain
    v = rand_vec();
    v[31:0] = 32'd1000;
    v[63:32] = -32'sd1000;
    send_vec(v, 1'b0, 3, 1'b0);
    @(negedge aclk);
    check("t1_word0", 64'(m_axis_tdata), 64'hFF83_007D);
    cnt = 0;
    while (m_axis_tvalid && cnt < 40) begin
      cnt++;
      @(negedge aclk);
    end
    check("t1_burst_len", 64'(cnt), 64'd16);
    check("t1_ready_back", 64'(in_ready), 64'd1);

    // Saturation at shift 0
    v = '0;
    v[31:0] = 32'h7FFF_FFFF;
    v[63:32] = 32'h8000_0000;
    send_vec(v, 1'b1, 0, 1'b0);
    @(negedge aclk);
    check("t2_word0", 64'(m_axis_tdata), 64'h8000_7FFF);
    wait_idle();
    check("t2_sat_count", 64'(sat_count), 64'(sat_model));

    // Rounding at shift 1
    v = '0;
    v[31:0] = 32'd3;
    v[63:32] = -32'sd3;
    v[95:64] = 32'd1;
    v[127:96] = -32'sd1;
    send_vec(v, 1'b0, 1, 1'b0);
    @(negedge aclk);
    check("t3_word0", 64'(m_axis_tdata), 64'hFFFF_0002);
    @(negedge aclk);
    check("t3_word1", 64'(m_axis_tdata), 64'h0000_0001);
    wait_idle();

    // Random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      send_vec(rand_vec(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // Back-to-back capture on the final-word handshake
    ready_mode = 1;
    repeat (2) @(posedge aclk);
    wait_idle();
    pulse(rand_vec(), 1'b0, int'($urandom_range(0, 20)), 1'b0);
    repeat (15) @(posedge aclk);
    #1;
    pulse(rand_vec(), 1'b1, int'($urandom_range(0, 20)), 1'b0);
    cnt = 0;
    repeat (16) begin
      @(negedge aclk);
      if (m_axis_tvalid) cnt++;
    end
    check("t5_no_bubble", 64'(cnt), 64'd16);
    @(negedge aclk);
    check("t5_done", 64'(m_axis_tvalid), 64'd0);
    check("t5_no_ovf", 64'(ovf_err), 64'd0);

    // Overflow while busy: rejected vector must not appear
    ready_mode = 0;
    repeat (2) @(posedge aclk);
    send_vec(rand_vec(), 1'b0, 4, 1'b0);
    @(posedge aclk);
    #1;
    v2 = rand_vec();
    in_data = v2; in_valid = 1'b1;
    @(posedge aclk);
    #1 in_valid = 1'b0;
    @(negedge aclk);
    check("t6_ovf_set", 64'(ovf_err), 64'd1);
    ready_mode = 2;
    wait_idle();
    check("t6_ovf_sticky", 64'(ovf_err), 64'd1);

    // Reset mid-drain
    ready_mode = 0;
    repeat (2) @(posedge aclk);
    send_vec(rand_vec(), 1'b1, 2, 1'b0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b1;
    exp_q.delete();
    @(posedge aclk);
    #1 areset = 1'b0;
    sat_model = 0;
    check("t7_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t7_in_ready", 64'(in_ready), 64'd1);
    check("t7_ovf_clr", 64'(ovf_err), 64'd0);
    check("t7_sat_clr", 64'(sat_count), 64'd0);

    // ReLU handling
    ready_mode = 1;
    repeat (2) @(posedge aclk);
    v = rand_vec();
    v[31:0] = -32'sd1000;
    send_vec(v, 1'b0, 0, 1'b1);
    @(negedge aclk);
`ifdef CONV_OUT_RELU_EN
    check("t8_relu_lane0", 64'(m_axis_tdata[15:0]), 64'h0000);
`else
    check("t8_relu_ignored", 64'(m_axis_tdata[15:0]), 64'hFC18);
`endif
    wait_idle();

    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      send_vec(rand_vec(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    check("final_sat_count", 64'(sat_count), 64'(sat_model));
    check("final_ovf", 64'(ovf_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
